fight_referee: RTL and testbench

- Parametrised combat referee for the VGA fighting game. It owns per-player health, hit invulnerability cooldown, round state and winner decision for NUM_PLAYERS fighters.
- It takes raw per-pixel sprite-overlap hit pulses and a per-frame tick. It produces health values for the health-bar drawers, a screen-flash request, and game-over/winner status for the top level.
- It supersedes the hand-wired two-player health, hit-flag and cooldown logic, generalised in player count, health width, damage and timing.

---
 rtl/fight_pkg.sv | 18 +
 rtl/fight_referee_if.sv | 27 ++
 rtl/hit_cooldown.sv | 64 ++++++
 rtl/fight_referee.sv | 132 +++++++++++++
 tb/tb_fight_referee.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fight_pkg.sv
// rtl/fight_pkg.sv - shared round-state encoding and sizing helpers for the fight referee.
package fight_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      FIGHT     = 2'd2,
      GAME_OVER = 2'd3
   } state_e;

   localparam int REGEN_PERIOD = 64;

   // Winner field must also encode the draw value NUM_PLAYERS.
   function automatic int winner_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fight_referee_if.sv
// rtl/fight_referee_if.sv - per-frame inputs and status outputs of the fight referee.
interface fight_referee_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int HEALTH_W    = 10
);
   localparam int WIN_W = fight_pkg::winner_w(NUM_PLAYERS);

   logic                            frame_tick;
   logic                            start;
   logic [NUM_PLAYERS-1:0]          hit_in;
   logic [NUM_PLAYERS*HEALTH_W-1:0] health;
   logic [NUM_PLAYERS-1:0]          invuln;
   logic                            flash;
   logic [1:0]                      state;
   logic                            game_over;
   logic [WIN_W-1:0]                winner;

   modport master (
      output frame_tick, start, hit_in,
      input  health, invuln, flash, state, game_over, winner
   );

   modport slave (
      input  frame_tick, start, hit_in,
      output health, invuln, flash, state, game_over, winner
   );
endinterface

// File: rtl/hit_cooldown.sv
// rtl/hit_cooldown.sv - one fighter's health, saturating damage, invulnerability cooldown and optional regen.
module hit_cooldown #(
   parameter int HEALTH_W        = 10,
   parameter int MAX_HEALTH      = 300,
   parameter int DAMAGE          = 100,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                reload,
   input  logic                fight_en,
   input  logic                hit,
   input  logic                frame_tick,
   input  logic                regen,
   output logic [HEALTH_W-1:0] health,
   output logic                invuln,
   output logic                health_zero
);
   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [HEALTH_W-1:0] MAXH = HEALTH_W'(MAX_HEALTH);
   localparam logic [HEALTH_W-1:0] DMG  = HEALTH_W'(DAMAGE);
   localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(COOLDOWN_FRAMES);

   logic [HEALTH_W-1:0] health_q, health_d;
   logic [CD_W-1:0]     cooldown_q, cooldown_d;
   logic                invuln_q, invuln_d;
   logic                cd_zero;

   assign cd_zero = (cooldown_q == '0);

   always_comb begin
      health_d   = health_q;
      cooldown_d = cooldown_q;
      invuln_d   = !cd_zero;
      if (frame_tick && !cd_zero)
         cooldown_d = cooldown_q - 1'b1;
      // A reload or accepted hit overrides the same-cycle frame decrement.
      if (reload) begin
         health_d   = MAXH;
         cooldown_d = '0;
      end else if (fight_en && hit && cd_zero) begin
         health_d   = (health_q > DMG) ? health_q - DMG : '0;
         cooldown_d = CD_LOAD;
      end else if (regen && cd_zero && health_q != '0 && health_q < MAXH) begin
         health_d = health_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         health_q   <= MAXH;
         cooldown_q <= '0;
         invuln_q   <= 1'b0;
      end else begin
         health_q   <= health_d;
         cooldown_q <= cooldown_d;
         invuln_q   <= invuln_d;
      end
   end

   assign health      = health_q;
   assign invuln      = invuln_q;
   assign health_zero = (health_q == '0);
endmodule

// File: rtl/fight_referee.sv
// rtl/fight_referee.sv - round FSM, countdown, winner encoder and per-player hit/cooldown units.
// Optional health regeneration in FIGHT is built when FIGHT_REGEN_EN is defined.
module fight_referee
   import fight_pkg::*;
#(
   parameter int NUM_PLAYERS      = 2,
   parameter int HEALTH_W         = 10,
   parameter int MAX_HEALTH       = 300,
   parameter int DAMAGE           = 100,
   parameter int COOLDOWN_FRAMES  = 30,
   parameter int COUNTDOWN_FRAMES = 60
) (
   input  logic            clk,
   input  logic            rst_n,
   fight_referee_if.slave  bus
);
   localparam int WIN_W = winner_w(NUM_PLAYERS);
   localparam int CNT_W = $clog2(COUNTDOWN_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COUNTDOWN_FRAMES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIN_W-1:0]       winner_q, winner_d, win_enc;
   logic [NUM_PLAYERS-1:0] health_zero;
   logic                   reload;
   logic                   fight_en;
   logic                   regen;

   assign fight_en = (state_q == FIGHT);

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      hit_cooldown #(
         .HEALTH_W        (HEALTH_W),
         .MAX_HEALTH      (MAX_HEALTH),
         .DAMAGE          (DAMAGE),
         .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
      ) u_hc (
         .clk         (clk),
         .rst_n       (rst_n),
         .reload      (reload),
         .fight_en    (fight_en),
         .hit         (bus.hit_in[g]),
         .frame_tick  (bus.frame_tick),
         .regen       (regen),
         .health      (bus.health[g*HEALTH_W +: HEALTH_W]),
         .invuln      (bus.invuln[g]),
         .health_zero (health_zero[g])
      );
   end

   // Lowest surviving index wins; no survivors encodes a draw as NUM_PLAYERS.
   always_comb begin
      win_enc = WIN_W'(NUM_PLAYERS);
      for (int i = NUM_PLAYERS - 1; i >= 0; i--)
         if (!health_zero[i]) win_enc = WIN_W'(i);
   end

`ifdef FIGHT_REGEN_EN
   localparam int RG_W = $clog2(REGEN_PERIOD);
   logic [RG_W-1:0] regen_cnt_q, regen_cnt_d;

   always_comb begin
      regen_cnt_d = regen_cnt_q;
      regen       = 1'b0;
      if (state_q != FIGHT) begin
         regen_cnt_d = '0;
      end else if (bus.frame_tick) begin
         if (regen_cnt_q == RG_W'(REGEN_PERIOD - 1)) begin
            regen       = 1'b1;
            regen_cnt_d = '0;
         end else begin
            regen_cnt_d = regen_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regen_cnt_q <= '0;
      else        regen_cnt_q <= regen_cnt_d;
   end
`else
   assign regen = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         winner_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         winner_q <= winner_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      reload   = 1'b0;
      case (state_q)
         IDLE, GAME_OVER: begin
            if (bus.start) begin
               state_d = COUNTDOWN;
               cnt_d   = CNT_LOAD;
               reload  = 1'b1;
            end
         end
         COUNTDOWN: begin
            if (bus.frame_tick) begin
               if (cnt_q == '0) state_d = FIGHT;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         FIGHT: begin
            if (|health_zero) begin
               state_d  = GAME_OVER;
               winner_d = win_enc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.state     = state_q;
      bus.game_over = (state_q == GAME_OVER);
      bus.flash     = |bus.invuln;
      bus.winner    = winner_q;
   end
endmodule

// File: tb/tb_fight_referee.sv
// tb/tb_fight_referee.sv - directed self-checking bench for fight_referee at default parameters.
module tb_fight_referee;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fight_referee_if #(.NUM_PLAYERS(2), .HEALTH_W(10)) bus ();

   fight_referee #(
      .NUM_PLAYERS(2), .HEALTH_W(10), .MAX_HEALTH(300), .DAMAGE(100),
      .COOLDOWN_FRAMES(30), .COUNTDOWN_FRAMES(60)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         @(negedge clk);
         bus.frame_tick = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_hit(input logic [1:0] h);
      bus.hit_in = h;
      @(negedge clk);
      bus.hit_in = 2'b00;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   function automatic logic [31:0] hp(input int p);
      return 32'(bus.health[p*10 +: 10]);
   endfunction

   initial begin
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      bus.hit_in     = 2'b00;
      cyc(3);
      chk("rst_state", bus.state, 0);
      chk("rst_h0", hp(0), 300);
      chk("rst_h1", hp(1), 300);
      chk("rst_invuln", bus.invuln, 0);
      chk("rst_flash", bus.flash, 0);
      chk("rst_go", bus.game_over, 0);
      chk("rst_winner", bus.winner, 0);
      rst_n = 1'b1;
      cyc(1);

      pulse_hit(2'b11);
      cyc(2);
      chk("idle_hit_h0", hp(0), 300);
      chk("idle_hit_inv", bus.invuln, 0);

      pulse_start();
      chk("start_cd", bus.state, 1);
      pulse_hit(2'b11);
      cyc(2);
      chk("cd_hit_h1", hp(1), 300);
      chk("cd_hit_inv", bus.invuln, 0);
      ticks(59);
      chk("cd_59", bus.state, 1);
      ticks(1);
      chk("cd_60_fight", bus.state, 2);
      chk("fight_h0", hp(0), 300);
      chk("fight_h1", hp(1), 300);

      // Held hit: one damage per cooldown window.
      bus.hit_in = 2'b01;
      cyc(1);
      chk("hold_h0_first", hp(0), 200);
      cyc(1);
      chk("hold_inv0", bus.invuln, 2'b01);
      chk("hold_flash", bus.flash, 1);
      ticks(29);
      chk("hold_h0_29", hp(0), 200);
      chk("hold_inv0_29", bus.invuln, 2'b01);
      ticks(1);
      chk("hold_h0_second", hp(0), 100);
      bus.hit_in = 2'b00;
      cyc(1);
      chk("hold_inv0_reload", bus.invuln[0], 1);

      // Hit coincident with frame_tick loads full cooldown.
      bus.hit_in     = 2'b10;
      bus.frame_tick = 1'b1;
      cyc(1);
      bus.hit_in     = 2'b00;
      bus.frame_tick = 1'b0;
      chk("coinc_h1", hp(1), 200);
      ticks(29);
      chk("coinc_inv1_29", bus.invuln[1], 1);
      ticks(1);
      chk("coinc_inv1_30", bus.invuln[1], 0);
      chk("coinc_flash_off", bus.flash, 0);

      // Player 0 KO, player 1 survives.
      pulse_hit(2'b11);
      chk("ko_h0", hp(0), 0);
      chk("ko_h1", hp(1), 100);
      chk("ko_go_1cyc", bus.game_over, 0);
      cyc(1);
      chk("ko_go_2cyc", bus.game_over, 1);
      chk("ko_state", bus.state, 3);
      chk("ko_winner", bus.winner, 1);

      ticks(31);
      chk("go_inv_clear", bus.invuln, 0);
      pulse_hit(2'b11);
      cyc(2);
      chk("go_hit_h0", hp(0), 0);
      chk("go_hit_h1", hp(1), 100);
      chk("go_hit_inv", bus.invuln, 0);
      chk("go_hold_winner", bus.winner, 1);

      // Restart, then simultaneous KO gives a draw.
      pulse_start();
      chk("restart_state", bus.state, 1);
      chk("restart_h0", hp(0), 300);
      chk("restart_h1", hp(1), 300);
      ticks(60);
      chk("restart_fight", bus.state, 2);
      pulse_hit(2'b11);
      chk("draw_h_200", hp(0) + hp(1), 400);
      ticks(31);
      pulse_hit(2'b11);
      chk("draw_h_100", hp(0) + hp(1), 200);
      ticks(31);
      pulse_hit(2'b11);
      chk("draw_h0_0", hp(0), 0);
      chk("draw_h1_0", hp(1), 0);
      chk("draw_go_1cyc", bus.game_over, 0);
      cyc(1);
      chk("draw_go_2cyc", bus.game_over, 1);
      chk("draw_winner", bus.winner, 2);

      // Asynchronous reset mid-fight.
      pulse_start();
      ticks(60);
      chk("rst2_fight", bus.state, 2);
      pulse_hit(2'b01);
      cyc(2);
      chk("rst2_pre_inv", bus.invuln, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", bus.state, 0);
      chk("arst_h0", hp(0), 300);
      chk("arst_inv", bus.invuln, 0);
      chk("arst_flash", bus.flash, 0);
      chk("arst_go", bus.game_over, 0);
      chk("arst_winner", bus.winner, 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
